// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - bus bundle between the pipeline/long-latency unit and rf_wb_arbiter
interface rf_wb_arbiter_if;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        stall_o;
  logic        hold_pipe_o;
  logic        err_o;
  logic        RegWrite_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  // pipeline / long-latency unit side
  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i,
    output ll_valid_i, ll_rd_i, ll_data_i,
    output issue_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  ll_ready_o, stall_o, hold_pipe_o, err_o,
    input  RegWrite_o, rd_addr_o, rd_data_o
  );

  // arbiter side
  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i,
    input  ll_valid_i, ll_rd_i, ll_data_i,
    input  issue_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    output ll_ready_o, stall_o, hold_pipe_o, err_o,
    output RegWrite_o, rd_addr_o, rd_data_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write port arbiter (pipeline WB vs long-latency FIFO), optional stats under RF_ARB_STATS_EN
module rf_wb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rf_wb_arbiter_if.slave     bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [31:0]        conflict_cnt_o,
  output logic [31:0]        hold_cnt_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MAX_DEFER + 1);

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] defer_q, defer_d;
  logic          hold_q, hold_d;
  logic [31:0]   busy_q, busy_d;
  logic          err_q;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [31:0]   data_q;

  logic          empty, full, wb_req, ll_acc, pop, push, bypass;
  logic          win_valid, win_ll;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;

  assign bus.ll_ready_o  = !full;
  assign bus.stall_o     = busy_q[bus.rs1_addr_i] | busy_q[bus.rs2_addr_i];
  assign bus.hold_pipe_o = hold_q;
  assign bus.err_o       = err_q;
  assign bus.RegWrite_o  = we_q;
  assign bus.rd_addr_o   = addr_q;
  assign bus.rd_data_o   = data_q;

  // pick this cycle's single write-port winner and the FIFO push/pop actions
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (AW+1)'(DEPTH));
    // a held pipeline has no right to the port; rd 0 requests never claim it
    wb_req    = bus.wb_valid_i && (bus.wb_rd_i != 5'd0) && !hold_q;
    ll_acc    = bus.ll_valid_i && !full;
    pop       = !empty && (hold_q || !wb_req);
    bypass    = ll_acc && empty && !wb_req;
    push      = ll_acc && !bypass;
    win_valid = 1'b0;
    win_ll    = 1'b0;
    win_rd    = 5'd0;
    win_data  = 32'd0;
    if (pop) begin
      win_valid = 1'b1;
      win_ll    = 1'b1;
      win_rd    = mem[rptr_q][36:32];
      win_data  = mem[rptr_q][31:0];
    end else if (wb_req) begin
      win_valid = 1'b1;
      win_rd    = bus.wb_rd_i;
      win_data  = bus.wb_data_i;
    end else if (bypass) begin
      win_valid = 1'b1;
      win_ll    = 1'b1;
      win_rd    = bus.ll_rd_i;
      win_data  = bus.ll_data_i;
    end
  end

  // starvation tracking and busy scoreboard next state
  always_comb begin
    defer_d = '0;
    if (!empty && !pop) begin
      defer_d = (defer_q == CW'(MAX_DEFER)) ? defer_q : defer_q + CW'(1);
    end
    hold_d = hold_q ? !pop : (defer_d == CW'(MAX_DEFER));
    busy_d = busy_q;
    // clearing lines up with the write appearing on the port; a same-cycle issue wins
    if (win_ll && (win_rd != 5'd0)) busy_d[win_rd] = 1'b0;
    if (bus.issue_i && (bus.issue_rd_i != 5'd0)) busy_d[bus.issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // FIFO storage; contents need no reset because count_q guards every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= {bus.ll_rd_i, bus.ll_data_i};
  end

  // control state, scoreboard and registered write-port outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      defer_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      defer_q <= defer_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      if (bus.wb_valid_i && hold_q) err_q <= 1'b1;
      we_q   <= win_valid && (win_rd != 5'd0);
      addr_q <= (win_valid && (win_rd != 5'd0)) ? win_rd : 5'd0;
      data_q <= (win_valid && (win_rd != 5'd0)) ? win_data : 32'd0;
    end
  end

`ifdef RF_ARB_STATS_EN
  // saturating event counters: wb/ll contention and held cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= 32'd0;
      hold_cnt_o     <= 32'd0;
    end else begin
      if (bus.wb_valid_i && (bus.wb_rd_i != 5'd0) && (bus.ll_valid_i || !empty) &&
          (conflict_cnt_o != 32'hFFFF_FFFF))
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      if (hold_q && (hold_cnt_o != 32'hFFFF_FFFF))
        hold_cnt_o <= hold_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter against a queue-based model
module tb_rf_wb_arbiter;
  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();

`ifdef RF_ARB_STATS_EN
  logic [31:0] conflict_cnt, hold_cnt;
`endif

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef RF_ARB_STATS_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .hold_cnt_o     (hold_cnt)
`endif
  );

  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  logic [36:0] m_q[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_hold, m_err, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wb_valid_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
    bus.ll_valid_i = 0; bus.ll_rd_i = 0; bus.ll_data_i = 0;
    bus.issue_i = 0; bus.issue_rd_i = 0; bus.rs1_addr_i = 0; bus.rs2_addr_i = 0;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 0; m_starve = 0; m_hold = 0; m_err = 0;
    m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic check_outputs();
    check_val("regwrite", bus.RegWrite_o, m_we);
    check_val("rd_addr",  bus.rd_addr_o,  m_addr);
    check_val("rd_data",  bus.rd_data_o,  m_data);
    check_val("hold",     bus.hold_pipe_o, m_hold);
    check_val("err",      bus.err_o,      m_err);
  endtask

  // one clock with the inputs currently on the bus; called just after a posedge
  task automatic step();
    int qs;
    bit acc, wb_claim, popped, from_ll, won;
    logic [36:0] e;
    logic [4:0]  wr;
    logic [31:0] wd;
    @(negedge clk);
    check_val("stall",    bus.stall_o,    m_busy[bus.rs1_addr_i] | m_busy[bus.rs2_addr_i]);
    check_val("ll_ready", bus.ll_ready_o, m_q.size() < DEPTH);
    qs = m_q.size();
    acc = bus.ll_valid_i && (qs < DEPTH);
    wb_claim = bus.wb_valid_i && (bus.wb_rd_i != 0) && !m_hold;
    popped = 0; from_ll = 0; won = 0; wr = 0; wd = 0;
    if (qs > 0 && (m_hold || !wb_claim)) begin
      e = m_q.pop_front();
      popped = 1; from_ll = 1; won = 1; wr = e[36:32]; wd = e[31:0];
    end else if (wb_claim) begin
      won = 1; wr = bus.wb_rd_i; wd = bus.wb_data_i;
    end else if (acc) begin
      won = 1; from_ll = 1; wr = bus.ll_rd_i; wd = bus.ll_data_i;
      acc = 0;
    end
    if (acc) m_q.push_back({bus.ll_rd_i, bus.ll_data_i});
    if (m_hold && bus.wb_valid_i) m_err = 1;
    m_we = won && (wr != 0);
    m_addr = m_we ? wr : 5'd0;
    m_data = m_we ? wd : 32'd0;
    if (from_ll && wr != 0) m_busy[wr] = 1'b0;
    if (bus.issue_i && bus.issue_rd_i != 0) m_busy[bus.issue_rd_i] = 1'b1;
    m_starve = (qs > 0 && !popped) ? m_starve + 1 : 0;
    m_hold = m_hold ? 1'b0 : (m_starve >= MAX_DEFER);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    #2;
    model_clear();
    check_outputs();
    check_val("rst_ready", bus.ll_ready_o, 1);
    check_val("rst_stall", bus.stall_o, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_clear();
    #1;
    do_reset();

    // WB only
    bus.wb_valid_i = 1; bus.wb_rd_i = 5; bus.wb_data_i = 32'hA5A5_A5A5;
    step();
    check_val("wb_only_addr", bus.rd_addr_o, 5);
    check_val("wb_only_data", bus.rd_data_o, 32'hA5A5_A5A5);
    idle();
    step();

    // WB and LL collide: rd 3 first, rd 7 next
    bus.wb_valid_i = 1; bus.wb_rd_i = 3; bus.wb_data_i = 32'h3333_0003;
    bus.ll_valid_i = 1; bus.ll_rd_i = 7; bus.ll_data_i = 32'h7777_0007;
    step();
    check_val("conflict_first", bus.rd_addr_o, 3);
    idle();
    step();
    check_val("conflict_second", bus.rd_addr_o, 7);

    // scoreboard on rd 9
    idle();
    bus.issue_i = 1; bus.issue_rd_i = 9; bus.rs1_addr_i = 9;
    step();
    bus.issue_i = 0;
    step();
    check_val("sb_stall_set", bus.stall_o, 1);
    bus.ll_valid_i = 1; bus.ll_rd_i = 9; bus.ll_data_i = 32'h0000_0999;
    step();
    check_val("sb_write_rd", bus.rd_addr_o, 9);
    check_val("sb_stall_clear", bus.stall_o, 0);
    idle();
    step();

    // starvation: wb held high, one ll rd 4 pending
    bus.wb_valid_i = 1; bus.wb_rd_i = 1; bus.wb_data_i = 32'h1111_1111;
    bus.ll_valid_i = 1; bus.ll_rd_i = 4; bus.ll_data_i = 32'h4444_4444;
    step();
    bus.ll_valid_i = 0;
    for (int i = 0; i < MAX_DEFER; i++) step();
    check_val("starve_hold", bus.hold_pipe_o, 1);
    step();
    check_val("starve_rd4", bus.rd_addr_o, 4);
    check_val("starve_hold_clear", bus.hold_pipe_o, 0);
    check_val("starve_err", bus.err_o, 1);
    bus.ll_valid_i = 1; bus.ll_rd_i = 6; bus.ll_data_i = 32'h6666_6666;
    step();

    // reset in the middle of traffic
    do_reset();

    // full FIFO
    for (int i = 0; i < DEPTH; i++) begin
      bus.wb_valid_i = 1; bus.wb_rd_i = 2; bus.wb_data_i = 32'h2222_0000 + i;
      bus.ll_valid_i = 1; bus.ll_rd_i = 5'(10 + i); bus.ll_data_i = 32'hABCD_0000 + i;
      step();
    end
    bus.wb_valid_i = 0;
    bus.ll_rd_i = 20; bus.ll_data_i = 32'hDEAD_BEEF;
    check_val("full_ready", bus.ll_ready_o, 0);
    step();
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // randomized traffic; the pipeline respects hold_pipe_o
    for (int n = 0; n < 500; n++) begin
      bus.wb_valid_i = m_hold ? 1'b0 : ($urandom_range(0, 99) < 60);
      bus.wb_rd_i    = 5'($urandom_range(0, 15));
      bus.wb_data_i  = $urandom;
      bus.ll_valid_i = ($urandom_range(0, 99) < 45);
      bus.ll_rd_i    = 5'($urandom_range(0, 15));
      bus.ll_data_i  = $urandom;
      bus.issue_i    = ($urandom_range(0, 99) < 30);
      bus.issue_rd_i = 5'($urandom_range(0, 15));
      bus.rs1_addr_i = 5'($urandom_range(0, 15));
      bus.rs2_addr_i = 5'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
